// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and instruction field layout for ctrl_sequencer
package ctrl_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    WEIGHTS = 2'b01,
    BIAS    = 2'b10,
    INPUTS  = 2'b11
  } load_sel_e;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ISSUE     = 2'b01,
    START     = 2'b10,
    WAIT_DONE = 2'b11
  } seq_state_e;

  // Fixed low fields: act[1:0], load_sel[3:2], data starts at bit 4
  localparam int ACT_LSB  = 0;
  localparam int SEL_LSB  = 2;
  localparam int DATA_LSB = 4;

  function automatic int instr_width(input int data_w, input int addr_w, input int cnt_w);
    return cnt_w + 1 + addr_w + data_w + 4;
  endfunction

  function automatic int addr_lsb(input int data_w);
    return data_w + 4;
  endfunction

  function automatic int start_bit(input int data_w, input int addr_w);
    return addr_w + data_w + 4;
  endfunction

  function automatic int cnt_lsb(input int data_w, input int addr_w);
    return addr_w + data_w + 5;
  endfunction

endpackage

// File: rtl/ctrl_sequencer_fifo.sv
// rtl/ctrl_sequencer_fifo.sv - synchronous FIFO holding queued instruction words
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed since reads are gated by occupancy
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Status and head-of-queue read
  always_comb begin
    rdata = mem_q[rd_ptr_q];
    full  = (count_q == DEPTH[AW:0]);
    empty = (count_q == '0);
    count = count_q;
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - queued instruction sequencer driving systolic array loads and start
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 2,
  parameter int CNT_W   = 4,
  parameter int DEPTH   = 4,
  parameter int INSTR_W = instr_width(DATA_W, ADDR_W, CNT_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [INSTR_W-1:0]  instr_data,
  input  logic                nn_done,
  output logic                busy,
  output logic [1:0]          activation_datapath,
  output logic                nn_start,
  output logic                load_weights,
  output logic                load_bias,
  output logic                load_inputs,
  output logic [DATA_W-1:0]   weight_data_in,
  output logic [DATA_W-1:0]   bias_data_in,
  output logic [DATA_W-1:0]   input_data_in,
  output logic [ADDR_W-1:0]   address
);

  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int CNT_LSB   = cnt_lsb(DATA_W, ADDR_W);
  localparam int START_BIT = start_bit(DATA_W, ADDR_W);
  localparam int ADDR_LSB  = addr_lsb(DATA_W);

  logic [INSTR_W-1:0] head;
  logic               fifo_full, fifo_empty, pop;
  logic [CW-1:0]      fifo_count;

  seq_state_e         state_q, state_d;
  load_sel_e          sel_q, sel_d;
  logic               start_q, start_d;
  logic [CNT_W-1:0]   beats_left_q, beats_left_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [1:0]         act_q, act_d;
  logic [DATA_W-1:0]  weight_q, weight_d;
  logic [DATA_W-1:0]  bias_q, bias_d;
  logic [DATA_W-1:0]  input_q, input_d;

  load_sel_e          h_sel;
  logic               h_start;
  logic [ADDR_W-1:0]  h_addr;
  logic [DATA_W-1:0]  h_data;
  logic [CNT_W-1:0]   h_count;
  logic [1:0]         h_act;

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (instr_valid),
    .wdata (instr_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Split the head-of-queue word into its fields
  always_comb begin
    h_count = head[CNT_LSB +: CNT_W];
    h_start = head[START_BIT];
    h_addr  = head[ADDR_LSB +: ADDR_W];
    h_data  = head[DATA_LSB +: DATA_W];
    h_sel   = load_sel_e'(head[SEL_LSB +: 2]);
    h_act   = head[ACT_LSB +: 2];
  end

  // State and latched-field registers; reset drops any burst or wait in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= NONE;
      start_q      <= 1'b0;
      beats_left_q <= '0;
      addr_q       <= '0;
      act_q        <= '0;
      weight_q     <= '0;
      bias_q       <= '0;
      input_q      <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      start_q      <= start_d;
      beats_left_q <= beats_left_d;
      addr_q       <= addr_d;
      act_q        <= act_d;
      weight_q     <= weight_d;
      bias_q       <= bias_d;
      input_q      <= input_d;
    end
  end

  // Next state: decide when to pop, then load the popped word's fields
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    start_d      = start_q;
    beats_left_d = beats_left_q;
    addr_d       = addr_q;
    act_d        = act_q;
    weight_d     = weight_q;
    bias_d       = bias_q;
    input_d      = input_q;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        pop = !fifo_empty;
      end
      ISSUE: begin
        if (beats_left_q == '0) begin
          if (start_q) begin
            state_d = START;
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          beats_left_d = beats_left_q - 1'b1;
          addr_d       = addr_q + 1'b1;
        end
      end
      START: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (nn_done) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      act_d        = h_act;
      sel_d        = h_sel;
      start_d      = h_start;
      beats_left_d = (h_count == '0) ? '0 : h_count - 1'b1;
      if (h_sel != NONE) begin
        addr_d = h_addr;
      end
      case (h_sel)
        WEIGHTS: weight_d = h_data;
        BIAS:    bias_d   = h_data;
        INPUTS:  input_d  = h_data;
        default: ;
      endcase
      if (h_sel != NONE) begin
        state_d = ISSUE;
      end else if (h_start) begin
        state_d = START;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Outputs: one strobe per ISSUE beat, start pulse in START, buses from registers
  always_comb begin
    load_weights        = 1'b0;
    load_bias           = 1'b0;
    load_inputs         = 1'b0;
    if (state_q == ISSUE) begin
      load_weights = (sel_q == WEIGHTS);
      load_bias    = (sel_q == BIAS);
      load_inputs  = (sel_q == INPUTS);
    end
    nn_start            = (state_q == START);
    busy                = (fifo_count != '0) || (state_q != IDLE);
    instr_ready         = !fifo_full;
    activation_datapath = act_q;
    address             = addr_q;
    weight_data_in      = weight_q;
    bias_data_in        = bias_q;
    input_data_in       = input_q;
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - directed self-checking bench for ctrl_sequencer
module tb_ctrl_sequencer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [26:0] instr_data;
  logic        nn_done;
  logic        busy;
  logic [1:0]  activation_datapath;
  logic        nn_start;
  logic        load_weights;
  logic        load_bias;
  logic        load_inputs;
  logic [15:0] weight_data_in;
  logic [15:0] bias_data_in;
  logic [15:0] input_data_in;
  logic [1:0]  address;

  int n_checks = 0;
  int n_fail   = 0;

  wire [3:0] strb = {load_weights, load_bias, load_inputs, nn_start};

  ctrl_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready),
    .instr_data          (instr_data),
    .nn_done             (nn_done),
    .busy                (busy),
    .activation_datapath (activation_datapath),
    .nn_start            (nn_start),
    .load_weights        (load_weights),
    .load_bias           (load_bias),
    .load_inputs         (load_inputs),
    .weight_data_in      (weight_data_in),
    .bias_data_in        (bias_data_in),
    .input_data_in       (input_data_in),
    .address             (address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [26:0] mk(input logic [3:0] c, input logic s, input logic [1:0] a,
                                     input logic [15:0] d, input logic [1:0] sel, input logic [1:0] act);
    return {c, s, a, d, sel, act};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_data = '0; nn_done = 1'b0;
    tick(); tick();
    check_eq("rst_strb", {28'd0, strb}, 32'h0);
    check_eq("rst_busy", {31'd0, busy}, 32'h0);
    check_eq("rst_ready", {31'd0, instr_ready}, 32'h1);
    check_eq("rst_addr", {30'd0, address}, 32'h0);
    check_eq("rst_wdata", {16'd0, weight_data_in}, 32'h0);
    rst = 1'b0;

    // Single weights burst of 3 from address 1
    instr_data = mk(4'd3, 1'b0, 2'd1, 16'h1234, 2'b01, 2'd2); instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    check_eq("t1_t1_strb", {28'd0, strb}, 32'h0);
    check_eq("t1_t1_busy", {31'd0, busy}, 32'h1);
    tick();
    check_eq("t1_b0_strb", {28'd0, strb}, 32'h8);
    check_eq("t1_b0_addr", {30'd0, address}, 32'h1);
    check_eq("t1_b0_wdata", {16'd0, weight_data_in}, 32'h1234);
    check_eq("t1_act", {30'd0, activation_datapath}, 32'h2);
    tick();
    check_eq("t1_b1_strb", {28'd0, strb}, 32'h8);
    check_eq("t1_b1_addr", {30'd0, address}, 32'h2);
    tick();
    check_eq("t1_b2_strb", {28'd0, strb}, 32'h8);
    check_eq("t1_b2_addr", {30'd0, address}, 32'h3);
    tick();
    check_eq("t1_end_strb", {28'd0, strb}, 32'h0);
    check_eq("t1_end_busy", {31'd0, busy}, 32'h0);

    // Bias burst of 2 wrapping address 3 -> 0
    instr_data = mk(4'd2, 1'b0, 2'd3, 16'h00FF, 2'b10, 2'd0); instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    tick();
    check_eq("t2_b0_strb", {28'd0, strb}, 32'h4);
    check_eq("t2_b0_addr", {30'd0, address}, 32'h3);
    check_eq("t2_bdata", {16'd0, bias_data_in}, 32'h00FF);
    check_eq("t2_whold", {16'd0, weight_data_in}, 32'h1234);
    tick();
    check_eq("t2_b1_strb", {28'd0, strb}, 32'h4);
    check_eq("t2_b1_addr", {30'd0, address}, 32'h0);
    tick();
    check_eq("t2_end_strb", {28'd0, strb}, 32'h0);
    check_eq("t2_end_busy", {31'd0, busy}, 32'h0);

    // Stray nn_done in IDLE, then inputs+start word followed by a queued weights word
    nn_done = 1'b1; tick(); nn_done = 1'b0;
    check_eq("t3_idle_busy", {31'd0, busy}, 32'h0);
    instr_data = mk(4'd1, 1'b1, 2'd0, 16'h0042, 2'b11, 2'd1); instr_valid = 1'b1;
    tick();
    instr_data = mk(4'd0, 1'b0, 2'd2, 16'hBEEF, 2'b01, 2'd0);
    tick(); instr_valid = 1'b0;
    check_eq("t3_in_strb", {28'd0, strb}, 32'h2);
    check_eq("t3_in_data", {16'd0, input_data_in}, 32'h0042);
    check_eq("t3_act", {30'd0, activation_datapath}, 32'h1);
    tick();
    check_eq("t3_start", {28'd0, strb}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t3_wait_strb", {28'd0, strb}, 32'h0);
      check_eq("t3_wait_busy", {31'd0, busy}, 32'h1);
    end
    nn_done = 1'b1; tick(); nn_done = 1'b0;
    check_eq("t3_after_strb", {28'd0, strb}, 32'h8);
    check_eq("t3_after_addr", {30'd0, address}, 32'h2);
    check_eq("t3_after_wdata", {16'd0, weight_data_in}, 32'hBEEF);
    tick();
    check_eq("t3_end_busy", {31'd0, busy}, 32'h0);

    // Back-to-back single-beat loads with no bubble
    instr_data = mk(4'd0, 1'b0, 2'd0, 16'h1111, 2'b01, 2'd0); instr_valid = 1'b1;
    tick();
    instr_data = mk(4'd1, 1'b0, 2'd1, 16'h2222, 2'b10, 2'd0);
    tick(); instr_valid = 1'b0;
    check_eq("t4_w_strb", {28'd0, strb}, 32'h8);
    check_eq("t4_w_addr", {30'd0, address}, 32'h0);
    tick();
    check_eq("t4_b_strb", {28'd0, strb}, 32'h4);
    check_eq("t4_b_addr", {30'd0, address}, 32'h1);
    check_eq("t4_b_data", {16'd0, bias_data_in}, 32'h2222);
    tick();
    check_eq("t4_end_busy", {31'd0, busy}, 32'h0);

    // FIFO full during a WAIT_DONE stall
    instr_data = mk(4'd0, 1'b1, 2'd0, 16'h0000, 2'b00, 2'd0); instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    check_eq("t5_t1_strb", {28'd0, strb}, 32'h0);
    tick();
    check_eq("t5_start", {28'd0, strb}, 32'h1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      instr_data = mk(4'd0, 1'b0, 2'd0, 16'(i), 2'b01, 2'd0); instr_valid = 1'b1;
      check_eq("t5_ready_fill", {31'd0, instr_ready}, 32'h1);
      tick();
    end
    check_eq("t5_full", {31'd0, instr_ready}, 32'h0);
    instr_data = mk(4'd0, 1'b0, 2'd0, 16'd5, 2'b01, 2'd0);
    tick();
    check_eq("t5_full_hold", {31'd0, instr_ready}, 32'h0);
    check_eq("t5_stall_strb", {28'd0, strb}, 32'h0);
    nn_done = 1'b1; tick(); nn_done = 1'b0;
    check_eq("t5_w1_strb", {28'd0, strb}, 32'h8);
    check_eq("t5_w1_data", {16'd0, weight_data_in}, 32'h1);
    check_eq("t5_ready_pop", {31'd0, instr_ready}, 32'h1);
    tick(); instr_valid = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      check_eq("t5_wn_strb", {28'd0, strb}, 32'h8);
      check_eq("t5_wn_data", {16'd0, weight_data_in}, 32'(i));
      tick();
    end
    check_eq("t5_end_busy", {31'd0, busy}, 32'h0);

    // Reset in the middle of an 8-beat inputs burst
    instr_data = mk(4'd8, 1'b0, 2'd0, 16'h5A5A, 2'b11, 2'd3); instr_valid = 1'b1;
    tick(); instr_valid = 1'b0;
    tick(); tick(); tick(); tick();
    check_eq("t6_b3_strb", {28'd0, strb}, 32'h2);
    check_eq("t6_b3_addr", {30'd0, address}, 32'h3);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("t6_rst_strb", {28'd0, strb}, 32'h0);
    check_eq("t6_rst_busy", {31'd0, busy}, 32'h0);
    check_eq("t6_rst_ready", {31'd0, instr_ready}, 32'h1);
    check_eq("t6_rst_addr", {30'd0, address}, 32'h0);
    check_eq("t6_rst_idata", {16'd0, input_data_in}, 32'h0);
    check_eq("t6_rst_act", {30'd0, activation_datapath}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t6_quiet_strb", {28'd0, strb}, 32'h0);
      check_eq("t6_quiet_busy", {31'd0, busy}, 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Sequential, parametrised successor to the combinational instruction decoder.
- Accepts instruction words over a valid/ready handshake into a small FIFO.
- Decodes each word and drives the load strobes, data buses and address to the systolic array and its buffers. A burst count repeats a load over consecutive addresses.
- An nn_start instruction pulses start, then stalls issue until the array reports done.
- Sits between the host/instruction source and the TPU datapath.

Parameters:
- DATA_W, 16, width of the weight/bias/input data field and buses.
- ADDR_W, 2, width of the address field and bus.
- CNT_W, 4, width of the burst-count field.
- DEPTH, 4, instruction FIFO entries (power of 2, at least 2).
- INSTR_W, CNT_W+1+ADDR_W+DATA_W+4, derived instruction width; never overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction word valid
- instr_ready  out  1  FIFO can accept a word
- instr_data  in  INSTR_W  instruction word
- nn_done  in  1  array finished the started pass
- busy  out  1  FIFO non-empty or FSM not IDLE
- activation_datapath  out  2  activation routing select
- nn_start  out  1  one-cycle start pulse
- load_weights  out  1  weight load strobe
- load_bias  out  1  bias load strobe
- load_inputs  out  1  input load strobe
- weight_data_in  out  DATA_W  weight data
- bias_data_in  out  DATA_W  bias data
- input_data_in  out  DATA_W  input data
- address  out  ADDR_W  load address

Behaviour:
- Field layout, MSB to LSB:
  - count [INSTR_W-1 -: CNT_W]
  - nn_start bit
  - address (ADDR_W)
  - data (DATA_W)
  - load_sel [3:2]: 00 none, 01 weights, 10 bias, 11 inputs
  - act [1:0]
  - With defaults: count[26:23], start[22], addr[21:20], data[19:4], sel[3:2], act[1:0]. A word with count=0 behaves as a single-beat legacy instruction.
- Reset (rst high at a clk edge):
  - All outputs 0, except instr_ready, which is 1 after reset.
  - FIFO emptied; FSM to IDLE.
  - Any in-flight burst or wait is discarded, with no further strobes.
- Handshake:
  - A word is written when instr_valid && instr_ready.
  - instr_ready = !full. When full it stays low even in a pop cycle (no same-cycle bypass).
  - instr_data is don't-care while instr_valid is low.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head, latch the fields, update activation_datapath (held until the next pop). Then:
    - load_sel != 00: go to ISSUE
    - load_sel == 00 and nn_start: go to START
    - otherwise: stay in IDLE (NOP)
  - ISSUE:
    - Beats = max(count,1).
    - Beat k (k from 0) asserts exactly one strobe for one cycle.
    - address = base + k mod 2^ADDR_W (wraps).
    - The selected data bus carries the latched data.
    - After the last beat:
      - if nn_start bit set: go to START
      - else if FIFO non-empty: pop directly (no bubble)
      - else: go to IDLE
  - START: nn_start high for exactly one cycle, then WAIT_DONE.
  - WAIT_DONE:
    - No issue.
    - nn_done sampled only here. On nn_done: pop the next word if available (as in IDLE), else go to IDLE.
    - nn_done outside WAIT_DONE is ignored.
- Latency: a word accepted in cycle t into an empty FIFO with FSM IDLE gives its first strobe (or nn_start) in cycle t+2.
- Strobes are mutually exclusive and low outside ISSUE.
- Data buses and address hold their last driven value between beats and instructions. Only the selected bus updates.

Decomposition:
- Shared package ctrl_pkg holds:
  - load_sel_e enum (NONE, WEIGHTS, BIAS, INPUTS)
  - seq_state_e enum (IDLE, ISSUE, START, WAIT_DONE)
  - field offset/width localparam functions of DATA_W/ADDR_W/CNT_W
- One sub-module, sync_fifo (WIDTH, DEPTH), providing full/empty and count.

Test Plan:
- Single word, sel=01, addr=1, data=0x1234, count=3, act=2: load_weights high 3 consecutive cycles from t+2; address 1,2,3; weight_data_in=0x1234; activation_datapath=2; then busy low.
- Wrap: sel=10, addr=3, data=0x00FF, count=2: load_bias on two beats; address 3 then 0; bias_data_in=0x00FF.
- Start/wait: word start=1 with sel=11, data=0x0042, count=1, then a second word sel=01 queued. Required:
  - load_inputs one cycle, then nn_start one cycle.
  - No strobe until the cycle after nn_done, which is driven 5 cycles later.
  - An nn_done pulse driven beforehand in IDLE is ignored.
- Back-to-back: two single-beat loads queued. Required: strobes in adjacent cycles, no bubble.
- Full: with a WAIT_DONE stall, push 5 words at DEPTH=4. Required: instr_ready low after the 4th accept; the 5th is accepted only after a pop.
- Reset mid-burst: count=8, rst high at beat 3. Required:
  - Outputs 0 the next cycle.
  - busy=0, instr_ready=1.
  - No further strobes until a new word is pushed.
